// File: rtl/detect_lowest_high.sv
// -----------------------------------------------------------------------------
// detect_lowest_high
//
// Purpose:
//   Reports the index of the lowest-order set bit of a wide input word (count of
//   trailing zeros). The search is a purely combinational priority encoder; its
//   result is registered, so Dout lags Din by exactly one clock and a new word
//   can be accepted every cycle.
//
// Ports:
//   clk   in   1      single clock, all state updates on the rising edge
//   rst   in   1      synchronous, active-high reset; loads Dout with 0
//   Din   in   WIDTH  word to scan, bit 0 is the LSB
//   Dout  out  OUT_W  registered index of the lowest '1' of Din, or WIDTH when
//                     Din is all zeros
//
// Parameters:
//   WIDTH  input vector width
//   OUT_W  output index width; 2**OUT_W must exceed WIDTH so that the
//          "no bit set" code (WIDTH) is representable
// -----------------------------------------------------------------------------
module detect_lowest_high #(
  parameter int WIDTH = 128,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Din,
  output logic [OUT_W-1:0] Dout
);

  // Code produced when no bit of Din is set.
  localparam logic [OUT_W-1:0] NONE_IDX = OUT_W'(WIDTH);

  // Priority search walking from the MSB down to the LSB, so the last match
  // written is the lowest set bit. Bits above the lowest set bit can only be
  // overwritten by it, which keeps X/Z there from reaching the result.
  function automatic logic [OUT_W-1:0] lowest_set_idx(input logic [WIDTH-1:0] d);
    logic [OUT_W-1:0] idx;
    idx = NONE_IDX;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i] == 1'b1) begin
        idx = OUT_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [OUT_W-1:0] dout_d;
  logic [OUT_W-1:0] dout_q;

  // Next-state: combinational index of the lowest set bit of the current word.
  always_comb begin
    dout_d = lowest_set_idx(Din);
  end

  // Result register; reset wins over the pending result on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= {OUT_W{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign Dout = dout_q;

endmodule

// File: tb/tb_detect_lowest_high.sv
// -----------------------------------------------------------------------------
// tb_detect_lowest_high
//
// Self-checking bench for detect_lowest_high at WIDTH=128, OUT_W=8. Inputs are
// driven on the falling edge; Dout is sampled 1 time unit after each rising
// edge and again just after the following falling edge (hold check, with Din
// already changed). Expected values come from an arithmetic reference model:
// isolate the lowest set bit with d & -d, then count the ones below it.
// -----------------------------------------------------------------------------
module tb_detect_lowest_high;

  localparam int WIDTH = 128;
  localparam int OUT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] Din;
  logic [OUT_W-1:0] Dout;

  int tests_run;
  int tests_failed;
  int exp_q;

  detect_lowest_high #(
    .WIDTH(WIDTH),
    .OUT_W(OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .Din (Din),
    .Dout(Dout)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: trailing-zero count via lowest-bit isolation and popcount.
  function automatic int ref_ctz(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] iso;
    if (d == '0) return WIDTH;
    iso = d & (~d + 128'd1);
    return $countones(iso - 128'd1);
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle: change inputs at the falling edge (confirming the previous
  // result is still held), then check the new result after the rising edge.
  task automatic step(input string tag, input logic [WIDTH-1:0] d, input logic r);
    @(negedge clk);
    Din = d;
    rst = r;
    #1;
    check_eq({tag, "_hold"}, int'(Dout), exp_q);
    @(posedge clk);
    exp_q = r ? 0 : ref_ctz(d);
    #1;
    check_eq(tag, int'(Dout), exp_q);
  endtask

  logic [WIDTH-1:0] one_w;
  logic [WIDTH-1:0] rnd;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    one_w        = 128'd1;
    Din          = '0;
    rst          = 1'b1;

    // Reset: Dout loaded with 0 regardless of Din.
    @(negedge clk);
    Din = 128'd5;
    @(posedge clk);
    #1;
    exp_q = 0;
    check_eq("reset", int'(Dout), 0);

    // Odd inputs.
    step("odd_a", 128'd1213213, 1'b0);
    step("odd_b", 128'd2223123513, 1'b0);
    // Single bits.
    step("bit1", 128'd2, 1'b0);
    step("bit2", 128'd4, 1'b0);
    step("bit3", 128'd8, 1'b0);
    // Mixed / boundaries.
    step("mix4444", 128'd4444, 1'b0);
    step("msb", one_w << 127, 1'b0);
    step("msb_b64", (one_w << 127) | (one_w << 64), 1'b0);
    step("zero", 128'd0, 1'b0);
    step("all_ones", ~128'd0, 1'b0);
    // Back-to-back.
    step("b2b_2", 128'd2, 1'b0);
    step("b2b_0", 128'd0, 1'b0);
    step("b2b_8", 128'd8, 1'b0);
    // Reset mid-stream, then release.
    step("mid_rst", 128'd8, 1'b1);
    step("rst_rel", 128'd8, 1'b0);

    // Explicit spot checks of the directed values against constants.
    step("c_msb", one_w << 127, 1'b0);
    check_eq("c_msb_const", int'(Dout), 127);
    step("c_zero", 128'd0, 1'b0);
    check_eq("c_zero_const", int'(Dout), 128);
    step("c_b64", (one_w << 127) | (one_w << 64), 1'b0);
    check_eq("c_b64_const", int'(Dout), 64);

    // Randomized stream with varied trailing-zero counts and sporadic reset.
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rnd = '0;
        1:       rnd = rnd | 128'd1;
        2:       rnd = one_w << $urandom_range(0, 127);
        default: rnd = rnd << $urandom_range(0, 127);
      endcase
      step("rand", rnd, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
